// File: rtl/fp_key_argmax.sv
// Streaming argmax/argmin over a vector of IEEE-style floats, returning the winning bit pattern and its index.
// Build option FP_KEY_ARGMAX_NAN_STICKY_EN: the first NaN of a vector wins instead of being skipped.
module fp_key_argmax #(
    parameter int EXP_W    = 8,
    parameter int MAN_W    = 23,
    parameter int IDX_W    = 16,
    parameter int FIND_MIN = 0,
    parameter int W        = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_nan,
    output logic             out_ovf
);

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    localparam logic [W-1:0]     SIGN_BIT = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]     QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [IDX_W-1:0] IDX_MAX  = '1;

    state_t            state_q, state_d;
    logic [W-1:0]      best_data_q, best_data_d;
    logic [W-1:0]      best_key_q, best_key_d;
    logic [IDX_W-1:0]  best_idx_q, best_idx_d;
    logic              best_valid_q, best_valid_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic              max_used_q, max_used_d;
    logic              ovf_q, ovf_d;
`ifdef FP_KEY_ARGMAX_NAN_STICKY_EN
    logic              nan_hit_q, nan_hit_d;
`endif

    logic              accept;
    logic              in_nan;
    logic [W-1:0]      in_canon;
    logic [W-1:0]      in_key;
    logic              better;
    logic              take;

    // -0 folds onto +0 so both map to the same key and tie on compare.
    always_comb begin
        in_nan   = (&in_data[W-2:MAN_W]) && (|in_data[MAN_W-1:0]);
        in_canon = (in_data == SIGN_BIT) ? '0 : in_data;
        in_key   = in_canon[W-1] ? ~in_canon : (in_canon ^ SIGN_BIT);
        better   = (FIND_MIN != 0) ? (in_key < best_key_q) : (in_key > best_key_q);
    end

    assign in_ready = (state_q != DONE);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d      = state_q;
        best_data_d  = best_data_q;
        best_key_d   = best_key_q;
        best_idx_d   = best_idx_q;
        best_valid_d = best_valid_q;
        cnt_d        = cnt_q;
        max_used_d   = max_used_q;
        ovf_d        = ovf_q;
        take         = 1'b0;
`ifdef FP_KEY_ARGMAX_NAN_STICKY_EN
        nan_hit_d    = nan_hit_q;
`endif

        case (state_q)
            IDLE, ACC: begin
                if (accept) begin
`ifdef FP_KEY_ARGMAX_NAN_STICKY_EN
                    if (!nan_hit_q) begin
                        if (in_nan) begin
                            nan_hit_d   = 1'b1;
                            best_data_d = in_data;
                            best_idx_d  = cnt_q;
                        end else begin
                            take = !best_valid_q || better;
                        end
                    end
`else
                    take = !in_nan && (!best_valid_q || better);
`endif
                    if (take) begin
                        best_data_d  = in_data;
                        best_key_d   = in_key;
                        best_idx_d   = cnt_q;
                        best_valid_d = 1'b1;
                    end
                    // Index parks at its maximum; a second beat landing there means overflow.
                    if (cnt_q == IDX_MAX) begin
                        if (max_used_q) ovf_d = 1'b1;
                        max_used_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    state_d = in_last ? DONE : ACC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d      = IDLE;
                    best_data_d  = '0;
                    best_key_d   = '0;
                    best_idx_d   = '0;
                    best_valid_d = 1'b0;
                    cnt_d        = '0;
                    max_used_d   = 1'b0;
                    ovf_d        = 1'b0;
`ifdef FP_KEY_ARGMAX_NAN_STICKY_EN
                    nan_hit_d    = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            best_data_q  <= '0;
            best_key_q   <= '0;
            best_idx_q   <= '0;
            best_valid_q <= 1'b0;
            cnt_q        <= '0;
            max_used_q   <= 1'b0;
            ovf_q        <= 1'b0;
`ifdef FP_KEY_ARGMAX_NAN_STICKY_EN
            nan_hit_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            best_data_q  <= best_data_d;
            best_key_q   <= best_key_d;
            best_idx_q   <= best_idx_d;
            best_valid_q <= best_valid_d;
            cnt_q        <= cnt_d;
            max_used_q   <= max_used_d;
            ovf_q        <= ovf_d;
`ifdef FP_KEY_ARGMAX_NAN_STICKY_EN
            nan_hit_q    <= nan_hit_d;
`endif
        end
    end

    always_comb begin
        out_valid = (state_q == DONE);
        out_data  = '0;
        out_idx   = '0;
        out_nan   = 1'b0;
        out_ovf   = 1'b0;
        if (state_q == DONE) begin
            out_ovf = ovf_q;
`ifdef FP_KEY_ARGMAX_NAN_STICKY_EN
            if (nan_hit_q) begin
                out_data = best_data_q;
                out_idx  = best_idx_q;
                out_nan  = 1'b1;
            end else
`endif
            if (best_valid_q) begin
                out_data = best_data_q;
                out_idx  = best_idx_q;
            end else begin
                out_data = QNAN;
                out_nan  = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fp_key_argmax.sv
// Directed bench: FP32 argmax, FP32 argmin and a small FP16 instance with a 2-bit index, driven from a vector table.
module tb_fp_key_argmax;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_last, out_ready;
    logic [31:0] in_data;
    int          sel;

    always #5 clk = ~clk;

    logic        r0, v0, n0, o0, r1, v1, n1, o1, r2, v2, n2, o2;
    logic [31:0] d0, d1;
    logic [15:0] d2, i0, i1;
    logic [1:0]  i2;

    fp_key_argmax u_max (
        .clk(clk), .rst(rst), .in_valid(in_valid && sel == 0), .in_ready(r0),
        .in_data(in_data), .in_last(in_last), .out_valid(v0),
        .out_ready(out_ready && sel == 0), .out_data(d0), .out_idx(i0),
        .out_nan(n0), .out_ovf(o0));

    fp_key_argmax #(.FIND_MIN(1)) u_min (
        .clk(clk), .rst(rst), .in_valid(in_valid && sel == 1), .in_ready(r1),
        .in_data(in_data), .in_last(in_last), .out_valid(v1),
        .out_ready(out_ready && sel == 1), .out_data(d1), .out_idx(i1),
        .out_nan(n1), .out_ovf(o1));

    fp_key_argmax #(.EXP_W(5), .MAN_W(10), .IDX_W(2)) u_h (
        .clk(clk), .rst(rst), .in_valid(in_valid && sel == 2), .in_ready(r2),
        .in_data(in_data[15:0]), .in_last(in_last), .out_valid(v2),
        .out_ready(out_ready && sel == 2), .out_data(d2), .out_idx(i2),
        .out_nan(n2), .out_ovf(o2));

    logic        a_ready, a_valid, a_nan, a_ovf;
    logic [31:0] a_data, a_idx;

    always_comb begin
        a_ready = r0; a_valid = v0; a_data = d0; a_idx = {16'h0, i0}; a_nan = n0; a_ovf = o0;
        if (sel == 1) begin
            a_ready = r1; a_valid = v1; a_data = d1; a_idx = {16'h0, i1}; a_nan = n1; a_ovf = o1;
        end else if (sel == 2) begin
            a_ready = r2; a_valid = v2; a_data = {16'h0, d2}; a_idx = {30'h0, i2}; a_nan = n2; a_ovf = o2;
        end
    end

    typedef struct {
        int          sel;
        int          n;
        logic [31:0] d [6];
        logic [31:0] ed;
        int          ei;
        bit          en;
        bit          eo;
    } vec_t;

    vec_t vt[$];
    int   total = 0;
    int   passed = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic add_vec(input int s, input int n,
                           input logic [31:0] b0, b1, b2, b3, b4, b5,
                           input logic [31:0] ed, input int ei, input bit en, input bit eo);
        vec_t v;
        v.sel = s; v.n = n;
        v.d[0] = b0; v.d[1] = b1; v.d[2] = b2; v.d[3] = b3; v.d[4] = b4; v.d[5] = b5;
        v.ed = ed; v.ei = ei; v.en = en; v.eo = eo;
        vt.push_back(v);
    endtask

    task automatic run_vec(input int k);
        bit    rdy_ok = 1'b1;
        string tag;
        tag = $sformatf("v%0d", k);
        sel = vt[k].sel;
        for (int b = 0; b < vt[k].n; b++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = vt[k].d[b];
            in_last  = (b == vt[k].n - 1);
            if (a_ready !== 1'b1) rdy_ok = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk({tag, " in_ready_during"}, {31'h0, rdy_ok}, 32'h1);
        chk({tag, " out_valid"}, {31'h0, a_valid}, 32'h1);
        chk({tag, " out_data"}, a_data, vt[k].ed);
        chk({tag, " out_idx"}, a_idx, vt[k].ei);
        chk({tag, " out_nan"}, {31'h0, a_nan}, {31'h0, vt[k].en});
        chk({tag, " out_ovf"}, {31'h0, a_ovf}, {31'h0, vt[k].eo});
        chk({tag, " in_ready_done"}, {31'h0, a_ready}, 32'h0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " out_valid_after"}, {31'h0, a_valid}, 32'h0);
        chk({tag, " in_ready_after"}, {31'h0, a_ready}, 32'h1);
    endtask

    initial begin
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; in_data = '0; sel = 0;
        rst = 1'b1;

        add_vec(0, 3, 32'h3F800000, 32'hC0000000, 32'h40600000, 0, 0, 0, 32'h40600000, 2, 0, 0);
        add_vec(1, 2, 32'h00000000, 32'h80000000, 0, 0, 0, 0, 32'h00000000, 0, 0, 0);
        add_vec(1, 2, 32'hBF800000, 32'hC0000000, 0, 0, 0, 0, 32'hC0000000, 1, 0, 0);
`ifdef FP_KEY_ARGMAX_NAN_STICKY_EN
        add_vec(0, 2, 32'h7FC00000, 32'h3F800000, 0, 0, 0, 0, 32'h7FC00000, 0, 1, 0);
        add_vec(0, 1, 32'h7FC00001, 0, 0, 0, 0, 0, 32'h7FC00001, 0, 1, 0);
        add_vec(1, 3, 32'h3F800000, 32'h7F800001, 32'h3F000000, 0, 0, 0, 32'h7F800001, 1, 1, 0);
`else
        add_vec(0, 2, 32'h7FC00000, 32'h3F800000, 0, 0, 0, 0, 32'h3F800000, 1, 0, 0);
        add_vec(0, 1, 32'h7FC00001, 0, 0, 0, 0, 0, 32'h7FC00000, 0, 1, 0);
        add_vec(1, 3, 32'h3F800000, 32'h7F800001, 32'h3F000000, 0, 0, 0, 32'h3F000000, 2, 0, 0);
`endif
        add_vec(2, 6, 32'h3C00, 32'h3C00, 32'h3C00, 32'h3C00, 32'h3C00, 32'h4000, 32'h4000, 3, 0, 1);
        add_vec(2, 4, 32'h3C00, 32'h4000, 32'h3C00, 32'h3800, 0, 0, 32'h4000, 1, 0, 0);
        add_vec(0, 2, 32'h40000000, 32'h40000000, 0, 0, 0, 0, 32'h40000000, 0, 0, 0);
        add_vec(0, 3, 32'hBF800000, 32'hC0000000, 32'hFF800000, 0, 0, 0, 32'hBF800000, 0, 0, 0);
        add_vec(0, 2, 32'h80000000, 32'h00000000, 0, 0, 0, 0, 32'h80000000, 0, 0, 0);
        add_vec(0, 1, 32'h40490FDB, 0, 0, 0, 0, 0, 32'h40490FDB, 0, 0, 0);
        add_vec(0, 2, 32'h7F7FFFFF, 32'h7F800000, 0, 0, 0, 0, 32'h7F800000, 1, 0, 0);
        add_vec(1, 3, 32'h3F800000, 32'hFF800000, 32'hC1000000, 0, 0, 0, 32'hFF800000, 1, 0, 0);

        repeat (2) @(negedge clk);
        chk("rst out_valid", {31'h0, v0}, 32'h0);
        chk("rst out_data", d0, 32'h0);
        chk("rst out_idx", {16'h0, i0}, 32'h0);
        chk("rst out_nan_ovf", {30'h0, n0, o0}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst in_ready", {29'h0, r0, r1, r2}, 32'h7);

        for (int k = 0; k < vt.size(); k++) run_vec(k);

        // Backpressure: result must hold, stray input must be refused.
        sel = 0;
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'h3F800000; in_last = 1'b1;
        @(negedge clk);
        in_data = 32'h50000000;
        for (int c = 0; c < 5; c++) begin
            chk("bp out_valid", {31'h0, a_valid}, 32'h1);
            chk("bp out_data", a_data, 32'h3F800000);
            chk("bp in_ready", {31'h0, a_ready}, 32'h0);
            @(negedge clk);
        end
        in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp release out_valid", {31'h0, a_valid}, 32'h0);
        chk("bp release in_ready", {31'h0, a_ready}, 32'h1);
        add_vec(0, 1, 32'h3F000000, 0, 0, 0, 0, 0, 32'h3F000000, 0, 0, 0);
        run_vec(vt.size() - 1);

        // Reset in the middle of a vector discards it.
        sel = 0;
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 32'h47000000; in_last = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("midrst out_valid", {31'h0, a_valid}, 32'h0);
            @(negedge clk);
        end
        chk("midrst in_ready", {31'h0, a_ready}, 32'h1);
        add_vec(0, 1, 32'h3F800000, 0, 0, 0, 0, 0, 32'h3F800000, 0, 0, 0);
        run_vec(vt.size() - 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
